ex_stage: RTL and testbench

Execute stage of the 5-stage in-order core: registers the ID→EX bus, computes the ALU result, drives the data SRAM request, and runs an iterative 32-bit divider that writes the HI/LO pair. Sits between ID and MEM, producing the 76-bit EX→MEM bus that MEM registers. While a divide is in flight it raises a stall request to the central stall controller, and it forwards its write-back triple to ID.

---
 rtl/ex_stage_pkg.sv | 91 +++++++++
 rtl/ex_stage_if.sv | 14 +
 rtl/div_iter.sv | 94 +++++++++
 rtl/ex_stage.sv | 98 +++++++++
 tb/tb_ex_stage.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, stall levels, ALU/divide op codes, bus layouts
// and the combinational ALU helper used by the execute stage.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 143;
  localparam int EX_TO_MEM_WD = 76;

  // Levels of one stall-bus bit.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MFHI = 4'd12;
  localparam logic [3:0] ALU_MFLO = 4'd13;
  localparam logic [3:0] ALU_PASS = 4'd14;

  localparam logic [1:0] DIV_NONE = 2'b00;
  localparam logic [1:0] DIV_S    = 2'b10;
  localparam logic [1:0] DIV_U    = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [1:0]  div_op;
    logic        ram_en;
    logic        ram_we;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] st_data;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  // Shift amounts come from src1[4:0]; the shifted value is src2.
  function automatic logic [31:0] alu_calc(input logic [3:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] hi,
                                           input logic [31:0] lo);
    logic [31:0] res;
    res = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_NOR:  res = ~(a | b);
      ALU_SLT:  res = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: res = {31'd0, a < b};
      ALU_SLL:  res = b << a[4:0];
      ALU_SRL:  res = b >> a[4:0];
      ALU_SRA:  res = $unsigned($signed(b) >>> a[4:0]);
      ALU_LUI:  res = {b[15:0], 16'd0};
      ALU_MFHI: res = hi;
      ALU_MFLO: res = lo;
      ALU_PASS: res = a;
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: data SRAM request issued by the execute stage.
//   en    - access enable
//   wen   - byte write enables (all four or none; word accesses only)
//   addr  - byte address
//   wdata - store data
interface ex_stage_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (output en, output wen, output addr, output wdata);
  modport slave  (input  en, input  wen, input  addr, input  wdata);
endinterface

// File: rtl/div_iter.sv
// div_iter: iterative 32-bit restoring divider, one quotient bit per cycle.
//   start     - launch request, accepted only while IDLE (operands latched then)
//   signed_op - 1 for signed divide
//   a, b      - dividend, divisor
//   ack       - releases DONE back to IDLE
//   busy/done - state flags; finish pulses during the last iteration cycle
//   quotient/remainder - sign-corrected result, valid while finish=1
//   state     - FSM state for observation
// Handshake: a request is taken when start=1 in IDLE; the result is held in
// DONE until ack=1, and DONE never accepts a new start.
module div_iter import ex_stage_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic        finish,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output div_state_t  state
);

  div_state_t  state_d;
  logic [4:0]  cnt;
  logic [31:0] q, r, d;
  logic        neg_q, neg_r;
  logic [31:0] mag_a, mag_b;
  logic [32:0] trial, diff;
  logic        fits;
  logic [31:0] q_next, r_next;

  assign mag_a = (signed_op && a[31]) ? (~a + 32'd1) : a;
  assign mag_b = (signed_op && b[31]) ? (~b + 32'd1) : b;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. A zero divisor always
  // fits, giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    trial  = {r, q[31]};
    diff   = trial - {1'b0, d};
    fits   = (trial >= {1'b0, d});
    q_next = {q[30:0], fits};
    r_next = fits ? diff[31:0] : trial[31:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      DIV_IDLE: if (start)        state_d = DIV_BUSY;
      DIV_BUSY: if (cnt == 5'd31) state_d = DIV_DONE;
      DIV_DONE: if (ack)          state_d = DIV_IDLE;
      default:                    state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      cnt   <= '0;
      q     <= mag_a;
      r     <= '0;
      d     <= mag_b;
      // Divide by zero keeps the raw all-ones quotient.
      neg_q <= signed_op && (a[31] ^ b[31]) && (b != 32'd0);
      neg_r <= signed_op && a[31];
    end else if (state == DIV_BUSY) begin
      cnt <= cnt + 5'd1;
      q   <= q_next;
      r   <= r_next;
    end
  end

  assign busy      = (state == DIV_BUSY);
  assign done      = (state == DIV_DONE);
  assign finish    = busy && (cnt == 5'd31);
  assign quotient  = neg_q ? (~q_next + 32'd1) : q_next;
  assign remainder = neg_r ? (~r_next + 32'd1) : r_next;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Registers the ID->EX bus, computes the ALU result
// and data SRAM request, runs the iterative divider into HI/LO.
//   clk, rst       - clock, asynchronous active-low reset
//   stall          - stall bus (bit 2 holds EX, bit 3 holds MEM)
//   id_to_ex_bus   - instruction fields from ID
//   ex_to_mem_bus  - {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_id       - forwarding {rf_we, rf_waddr, ex_result}
//   stall_for_ex   - divide in progress, hold the pipeline
//   data_sram      - data SRAM request
//   div_state      - divider FSM state for observation
module ex_stage import ex_stage_pkg::*; (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_id,
  output logic                    stall_for_ex,
  ex_stage_if.master              data_sram,
  output div_state_t              div_state
);

  id_ex_t      r;
  ex_mem_t     m;
  logic [31:0] hi, lo;
  logic [31:0] alu_res, addr, ex_result;
  logic [3:0]  wen;
  logic        is_div;
  logic        div_busy, div_done, div_finish;
  logic [31:0] div_q, div_r;
  logic        unused_bits;

  // EX held while MEM advances means the instruction leaves: insert a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      r <= '0;
    else if (stall[2] == STOP && stall[3] == NO_STOP) r <= '0;
    else if (stall[2] == NO_STOP)                  r <= id_ex_t'(id_to_ex_bus);
  end

  // div_op 01 is treated as no divide, so only the MSB marks a divide.
  assign is_div = r.div_op[1];

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_op (r.div_op == DIV_S),
    .a         (r.src1),
    .b         (r.src2),
    .ack       (stall[2] == NO_STOP),
    .busy      (div_busy),
    .done      (div_done),
    .finish    (div_finish),
    .quotient  (div_q),
    .remainder (div_r),
    .state     (div_state)
  );

  // HI/LO load once, on the edge that moves the divider into DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_finish) begin
      hi <= div_r;
      lo <= div_q;
    end
  end

  assign stall_for_ex = is_div && !div_done;

  assign alu_res   = alu_calc(r.alu_op, r.src1, r.src2, hi, lo);
  assign addr      = r.src1 + r.src2;
  assign wen       = (r.ram_en && r.ram_we) ? 4'hF : 4'h0;
  assign ex_result = r.ram_en ? addr : alu_res;

  assign data_sram.en    = r.ram_en;
  assign data_sram.wen   = wen;
  assign data_sram.addr  = addr;
  assign data_sram.wdata = r.st_data;

  always_comb begin
    m              = '0;
    m.pc           = r.pc;
    m.data_ram_en  = r.ram_en;
    m.data_ram_wen = wen;
    m.sel_rf_res   = r.sel_rf_res;
    m.rf_we        = r.rf_we;
    m.rf_waddr     = r.rf_waddr;
    m.ex_result    = ex_result;
  end

  assign ex_to_mem_bus = m;
  assign ex_to_id      = {r.rf_we, r.rf_waddr, ex_result};

  assign unused_bits = ^{stall[5:4], stall[1:0], div_busy};

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic                    clk;
  logic                    rst;
  logic [5:0]              stall;
  logic [ID_TO_EX_WD-1:0]  id_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [37:0]             ex_to_id;
  logic                    stall_for_ex;
  div_state_t              div_state;
  logic                    hold;
  logic                    bubble;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  ex_stage_if sram_if ();

  ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .id_to_ex_bus  (id_bus),
    .ex_to_mem_bus (ex_to_mem_bus),
    .ex_to_id      (ex_to_id),
    .stall_for_ex  (stall_for_ex),
    .data_sram     (sram_if),
    .div_state     (div_state)
  );

  // ---------------- clock / reset / stall controller ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // EX stall requests and MEM-side holds freeze PC..EX; bubble = EX held
  // while MEM moves on.
  assign stall = bubble ? 6'b000111 :
                 ((stall_for_ex || hold) ? 6'b001111 : 6'b000000);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [142:0] mk(input logic [31:0] pc, input logic [3:0] op,
                                      input logic [1:0] dop, input logic ram_en,
                                      input logic ram_we, input logic sel,
                                      input logic rf_we, input logic [4:0] waddr,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] st);
    return {pc, op, dop, ram_en, ram_we, sel, rf_we, waddr, s1, s2, st};
  endfunction

  // Reference ALU written from the operation definitions.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
    logic [31:0] x;
    int s;
    s = int'(a[4:0]);
    x = b;
    case (op)
      0:  return a + b;
      1:  return a + ~b + 32'd1;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7:  return (a < b) ? 32'd1 : 32'd0;
      8:  begin repeat (s) x = x * 32'd2; return x; end
      9:  begin repeat (s) x = x / 32'd2; return x; end
      10: begin repeat (s) x = {x[31], x[31:1]}; return x; end
      11: return b * 32'd65536;
      12: return hi;
      13: return lo;
      14: return a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void ref_div(input logic [1:0] dop, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] lo,
                                  output logic [31:0] hi);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
      return;
    end
    if (dop == 2'b10) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    lo = q[31:0];
    hi = r[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [142:0] instr);
    @(negedge clk);
    id_bus = instr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(input logic [1:0] dop, input logic [31:0] a,
                        input logic [31:0] b, input int hold_cycles);
    int cnt;
    logic [31:0] elo, ehi;
    ref_div(dop, a, b, elo, ehi);
    apply(mk(32'h0040_0100, 4'd15, dop, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, a, b, 32'd0));
    cnt = 0;
    for (int k = 0; k < 100 && stall_for_ex; k++) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("div_stall_cycles", 128'(cnt), 128'd33);
    check("div_done_state", 128'(div_state), 128'(DIV_DONE));
    id_bus = mk(32'h0040_0104, 4'd13, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd0, 32'd0, 32'd0);
    if (hold_cycles > 0) begin
      hold = 1'b1;
      for (int k = 0; k < hold_cycles; k++) begin
        @(posedge clk);
        #1;
        check("hold_done_no_restart", {stall_for_ex, 2'(div_state)}, {1'b0, 2'(DIV_DONE)});
      end
      hold = 1'b0;
    end
    @(posedge clk);
    #1;
    m_lo = elo;
    m_hi = ehi;
    check("mflo_after_div", 128'(ex_to_mem_bus[31:0]), 128'(elo));
    check("idle_after_div", {stall_for_ex, 2'(div_state)}, {1'b0, 2'(DIV_IDLE)});
    apply(mk(32'h0040_0108, 4'd12, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd0, 32'd0, 32'd0));
    check("mfhi_after_div", 128'(ex_to_mem_bus[31:0]), 128'(ehi));
    apply('0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [3:0]  op;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] st;
    logic [31:0] res;
    logic [3:0]  wen;
    logic [31:0] addr;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [142:0] instr;
    logic [31:0]  pc, s1, s2, st, er;
    logic [3:0]   op;
    logic         en, we;

    vt[0] = '{4'd0,  1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1,         32'h0,         32'h8000_0000, 4'h0, 32'h8000_0000};
    vt[1] = '{4'd10, 1'b0, 1'b0, 32'h4,         32'h8000_0000, 32'h0,         32'hF800_0000, 4'h0, 32'h8000_0004};
    vt[2] = '{4'd6,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h1,         4'h0, 32'h0};
    vt[3] = '{4'd7,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         4'h0, 32'h0};
    vt[4] = '{4'd0,  1'b1, 1'b1, 32'h100,       32'h8,         32'hDEAD_BEEF, 32'h108,       4'hF, 32'h108};
    vt[5] = '{4'd0,  1'b1, 1'b0, 32'h200,       32'h10,        32'h1234_5678, 32'h210,       4'h0, 32'h210};
    vt[6] = '{4'd11, 1'b0, 1'b0, 32'h0,         32'h1234,      32'h0,         32'h1234_0000, 4'h0, 32'h1234};
    vt[7] = '{4'd5,  1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFF, 4'h0, 32'h0};
    vt[8] = '{4'd15, 1'b0, 1'b0, 32'h5,         32'h6,         32'h0,         32'h0,         4'h0, 32'hB};
    vt[9] = '{4'd1,  1'b0, 1'b0, 32'h3,         32'h5,         32'h0,         32'hFFFF_FFFE, 4'h0, 32'h8};

    rst = 1'b0;
    hold = 1'b0;
    bubble = 1'b0;
    id_bus = '0;
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ex_to_mem", 128'(ex_to_mem_bus), 128'd0);
    check("reset_sram", {sram_if.en, sram_if.wen, sram_if.addr, sram_if.wdata}, 128'd0);
    check("reset_stall_state", {stall_for_ex, 2'(div_state)}, {1'b0, 2'(DIV_IDLE)});
    @(negedge clk);
    rst = 1'b1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 10; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      apply(mk(pc, vt[i].op, 2'b00, vt[i].ram_en, vt[i].ram_we,
               vt[i].ram_en & ~vt[i].ram_we, 1'b1, 5'(i + 1), vt[i].s1, vt[i].s2, vt[i].st));
      check("vec_bus", 128'(ex_to_mem_bus),
            128'({pc, vt[i].ram_en, vt[i].wen, vt[i].ram_en & ~vt[i].ram_we, 1'b1, 5'(i + 1), vt[i].res}));
      check("vec_sram", {sram_if.en, sram_if.wen, sram_if.addr, sram_if.wdata},
            {vt[i].ram_en, vt[i].wen, vt[i].addr, vt[i].st});
      check("vec_fwd", 128'(ex_to_id), 128'({1'b1, 5'(i + 1), vt[i].res}));
      check("vec_no_stall", 128'(stall_for_ex), 128'd0);
    end

    // Hold then bubble.
    apply(mk(32'h2000, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'd1, 32'd2, 32'd0));
    check("pre_hold", 128'(ex_to_mem_bus[31:0]), 128'd3);
    @(negedge clk);
    id_bus = mk(32'h2004, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd10, 32'd4, 32'd0);
    hold = 1'b1;
    @(posedge clk);
    #1;
    check("hold_keeps_instr", 128'(ex_to_mem_bus[31:0]), 128'd3);
    @(negedge clk);
    hold = 1'b0;
    bubble = 1'b1;
    @(posedge clk);
    #1;
    check("bubble_bus", {ex_to_mem_bus, ex_to_id}, 128'd0);
    @(negedge clk);
    bubble = 1'b0;
    @(posedge clk);
    #1;
    check("after_bubble", 128'(ex_to_mem_bus[31:0]), 128'd6);

    // Directed divides.
    do_div(DIV_S, 32'hFFFF_FFF9, 32'd2, 0);
    do_div(DIV_U, 32'd5, 32'd0, 0);
    do_div(DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(DIV_S, 32'd77, 32'hFFFF_FFF6, 5);

    // Reset in the middle of a divide.
    apply(mk(32'hBFC0_0040, 4'd0, DIV_U, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'd1000, 32'd3, 32'h55));
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_reset", {stall_for_ex, 2'(div_state)}, {1'b1, 2'(DIV_BUSY)});
    rst = 1'b0;
    #1;
    check("midreset_bus", {ex_to_mem_bus, ex_to_id}, 128'd0);
    check("midreset_sram", {sram_if.en, sram_if.wen, sram_if.addr, sram_if.wdata}, 128'd0);
    check("midreset_state", {stall_for_ex, 2'(div_state)}, {1'b0, 2'(DIV_IDLE)});
    id_bus = '0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    apply(mk(32'h10, 4'd13, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 32'd0, 32'd0));
    check("lo_cleared", 128'(ex_to_mem_bus[31:0]), 128'd0);
    apply(mk(32'h14, 4'd12, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 32'd0, 32'd0));
    check("hi_cleared", 128'(ex_to_mem_bus[31:0]), 128'd0);
    do_div(DIV_U, 32'd100, 32'd7, 0);

    // Random divides.
    for (int i = 0; i < 6; i++) begin
      s1 = $urandom;
      case ($urandom_range(0, 3))
        0:       s2 = 32'd0;
        1:       s2 = 32'($urandom_range(1, 50));
        2:       s2 = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: s2 = $urandom;
      endcase
      do_div(($urandom_range(0, 1) == 1) ? DIV_S : DIV_U, s1, s2, 0);
    end

    // Random single-cycle operations through the scoreboard queue.
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) == 0);
      we = en && ($urandom_range(0, 1) == 1);
      s1 = $urandom;
      s2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      st = $urandom;
      pc = $urandom;
      exp_q.push_back(en ? (s1 + s2) : ref_alu(int'(op), s1, s2, m_hi, m_lo));
      instr = mk(pc, op, 2'b00, en, we, 1'b0, 1'b1, 5'd7, s1, s2, st);
      apply(instr);
      er = exp_q.pop_front();
      check("rand_result", 128'(ex_to_mem_bus[31:0]), 128'(er));
      check("rand_sram", {sram_if.en, sram_if.wen, sram_if.addr, sram_if.wdata},
            {en, (en && we) ? 4'hF : 4'h0, s1 + s2, st});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
